sd_init_sequencer: RTL and testbench
====================================

Name: sd_init_sequencer

Overview:
Upstream sequencer that drives the SD command engine (`sd_controller`) through the SPI-mode card initialisation flow. It replaces the ad-hoc start counter in the top level. The flow is: power-up dummy clocks, CMD0, CMD8, the CMD55/ACMD41 loop, then CMD58. It checks each R1/R7/R3 response, classifies the card (v1 / v2-SC / v2-HC), and reports success or a coded error.

Parameters:
CMD0_RETRIES, 8, max CMD0 attempts before error
ACMD41_RETRIES, 1000, max ACMD41 attempts while card reports idle (R1=0x01)
POWERUP_BYTES, 10, number of 0xFF bytes sent with ss_n high before CMD0 (>=74 clocks)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
init_start  input  1  one-cycle pulse; starts the sequence from IDLE/DONE/ERR
ss_n  output  1  card chip-select, active-low
dummy_start  output  1  one-cycle pulse; engine sends dummy_nbytes of 0xFF
dummy_nbytes  output  8  equals POWERUP_BYTES
dummy_done  input  1  one-cycle pulse; dummy bytes finished
cmd_start  output  1  one-cycle pulse to command engine
cmd_index  output  6  command index
cmd_arg  output  32  command argument
cmd_crc  output  7  CRC7 field
cmd_nresp  output  3  response bytes expected (1 or 5)
cmd_done  input  1  one-cycle pulse; response valid this cycle
resp_r1  input  8  R1 byte
resp_ext  input  32  trailing 4 bytes (R3/R7), MSB first
init_busy  output  1  high from accepted init_start until DONE/ERR
init_ok  output  1  high in DONE
init_err  output  1  high in ERR
err_code  output  3  0 none, 1 CMD0 fail, 2 CMD8 bad echo/R1, 3 unexpected R1, 4 ACMD41 timeout, 5 CMD58 fail
card_v2  output  1  card answered CMD8 correctly
card_hc  output  1  CCS bit from OCR (v2 only)

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 except ss_n=1; retry counters cleared.
- States and transitions:
  - IDLE: on init_start go to PWR and pulse dummy_start.
  - PWR: ss_n=1; wait for dummy_done, then go to C0.
  - Cx: one-cycle issue state that pulses cmd_start; the next state is Wx.
  - Wx: wait for cmd_done and evaluate the response.
- ss_n is 0 in every Cx/Wx state and 1 in IDLE, PWR, DONE and ERR.
- cmd_index/arg/crc/nresp are registered in Cx and held stable until cmd_done.
- Command table (index, arg, crc, nresp):
  - CMD0: 0, 0x00000000, 0x4A, 1
  - CMD8: 8, 0x000001AA, 0x43, 5
  - CMD55: 55, 0, 0x7F, 1
  - ACMD41: 41, card_v2 ? 0x40000000 : 0, 0x7F, 1
  - CMD58: 58, 0, 0x7F, 5
- W0:
  - R1=0x01 -> C8.
  - Otherwise: increment the CMD0 counter and reissue C0. When the counter reaches CMD0_RETRIES -> ERR code 1.
- W8:
  - R1=0x01 and resp_ext[11:0]=0x1AA -> card_v2=1, C55.
  - R1 with bit2 set (0x05, illegal command) -> card_v2=0, C55.
  - Anything else -> ERR code 2.
- W55: R1 in {0x00, 0x01} -> C41; else ERR code 3.
- W41:
  - R1=0x00 -> C58 if card_v2, else DONE with card_hc=0.
  - R1=0x01 -> increment the ACMD41 counter and go to C55. When the counter reaches ACMD41_RETRIES -> ERR code 4.
  - Any other value -> ERR code 3.
- W58: R1=0x00 -> card_hc=resp_ext[30], DONE; else ERR code 5.
- DONE/ERR: hold outputs. A new init_start clears err_code, card_v2, card_hc and the counters, then goes to PWR.
- Ignored inputs:
  - init_start while busy.
  - cmd_done outside Wx.
  - dummy_done outside PWR.
- If init_start coincides with a stray cmd_done in DONE, the init_start wins.
- Counters saturate and never wrap. Widths are $clog2(N+1).
- Latency: cmd_start follows the previous cmd_done by exactly 2 cycles (Wx evaluate -> Cx issue -> pulse registered).
- init_busy drops the same cycle init_ok/init_err rises.

Test Plan:
- v2-HC card: CMD0 R1=0x01; CMD8 R1=0x01, ext=0x000001AA; two ACMD41 R1=0x01 then 0x00; CMD58 R1=0, ext=0xC0FF8000 -> command order 0,8,55,41,55,41,55,41,58; init_ok=1, card_v2=1, card_hc=1, err_code=0.
- v1 card: CMD8 R1=0x05 -> ACMD41 arg=0; CMD58 never issued; init_ok=1, card_v2=0, card_hc=0.
- Dead card: CMD0 always R1=0xFF -> exactly 8 cmd_start pulses, then init_err=1, err_code=1, ss_n=1.
- CMD8 echo mismatch (ext=0x000001AB) -> ERR code 2; ACMD41 always 0x01 with ACMD41_RETRIES=4 -> ERR code 4 after 4 ACMD41 commands.
- Reset asserted in W41 -> next cycle ss_n=1, cmd_start=0, init_busy=0. A fresh init_start restarts with dummy_start, and ss_n stays high until dummy_done.
- Protocol checks: cmd_start timing is 2 cycles after cmd_done; init_start pulsed during W8 is ignored; re-init from DONE clears card_hc before CMD0.

Source files
------------

// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card initialisation sequencer: drives the command engine through power-up,
// CMD0, CMD8, the CMD55/ACMD41 loop and CMD58, classifying the card or reporting an error.
module sd_init_sequencer #(
    parameter int unsigned CMD0_RETRIES   = 8,
    parameter int unsigned ACMD41_RETRIES = 1000,
    parameter int unsigned POWERUP_BYTES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_start_i,
    output logic        ss_n_o,
    output logic        dummy_start_o,
    output logic [7:0]  dummy_nbytes_o,
    input  logic        dummy_done_i,
    output logic        cmd_start_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic [6:0]  cmd_crc_o,
    output logic [2:0]  cmd_nresp_o,
    input  logic        cmd_done_i,
    input  logic [7:0]  resp_r1_i,
    input  logic [31:0] resp_ext_i,
    output logic        init_busy_o,
    output logic        init_ok_o,
    output logic        init_err_o,
    output logic [2:0]  err_code_o,
    output logic        card_v2_o,
    output logic        card_hc_o
);

    localparam int unsigned C0W  = $clog2(CMD0_RETRIES + 1);
    localparam int unsigned A41W = $clog2(ACMD41_RETRIES + 1);
    // Last attempt index: reaching it on a failed response means the budget is spent.
    localparam logic [C0W-1:0]  C0Last  = C0W'(CMD0_RETRIES - 1);
    localparam logic [A41W-1:0] A41Last = A41W'(ACMD41_RETRIES - 1);

    typedef enum logic [3:0] {
        StIdle, StPwr, StC0, StW0, StC8, StW8, StC55, StW55,
        StC41, StW41, StC58, StW58, StDone, StErr
    } state_e;

    state_e           state_q;
    logic             ss_n_q, dummy_start_q, cmd_start_q;
    logic [5:0]       cmd_index_q;
    logic [31:0]      cmd_arg_q;
    logic [6:0]       cmd_crc_q;
    logic [2:0]       cmd_nresp_q;
    logic             busy_q, ok_q, err_q, card_v2_q, card_hc_q;
    logic [2:0]       err_code_q;
    logic [C0W-1:0]   c0_cnt_q;
    logic [A41W-1:0]  a41_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ss_n_q        <= 1'b1;
            dummy_start_q <= 1'b0;
            cmd_start_q   <= 1'b0;
            cmd_index_q   <= '0;
            cmd_arg_q     <= '0;
            cmd_crc_q     <= '0;
            cmd_nresp_q   <= '0;
            busy_q        <= 1'b0;
            ok_q          <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
            card_v2_q     <= 1'b0;
            card_hc_q     <= 1'b0;
            c0_cnt_q      <= '0;
            a41_cnt_q     <= '0;
        end else begin
            dummy_start_q <= 1'b0;
            cmd_start_q   <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (init_start_i) begin
                        state_q       <= StPwr;
                        dummy_start_q <= 1'b1;
                        busy_q        <= 1'b1;
                        ok_q          <= 1'b0;
                        err_q         <= 1'b0;
                        err_code_q    <= '0;
                        card_v2_q     <= 1'b0;
                        card_hc_q     <= 1'b0;
                        c0_cnt_q      <= '0;
                        a41_cnt_q     <= '0;
                    end
                end
                StPwr: begin
                    if (dummy_done_i) begin
                        state_q <= StC0;
                        ss_n_q  <= 1'b0;
                    end
                end
                StC0: begin
                    cmd_start_q <= 1'b1;
                    cmd_index_q <= 6'd0;
                    cmd_arg_q   <= 32'h0000_0000;
                    cmd_crc_q   <= 7'h4A;
                    cmd_nresp_q <= 3'd1;
                    state_q     <= StW0;
                end
                StC8: begin
                    cmd_start_q <= 1'b1;
                    cmd_index_q <= 6'd8;
                    cmd_arg_q   <= 32'h0000_01AA;
                    cmd_crc_q   <= 7'h43;
                    cmd_nresp_q <= 3'd5;
                    state_q     <= StW8;
                end
                StC55: begin
                    cmd_start_q <= 1'b1;
                    cmd_index_q <= 6'd55;
                    cmd_arg_q   <= 32'h0000_0000;
                    cmd_crc_q   <= 7'h7F;
                    cmd_nresp_q <= 3'd1;
                    state_q     <= StW55;
                end
                StC41: begin
                    cmd_start_q <= 1'b1;
                    cmd_index_q <= 6'd41;
                    cmd_arg_q   <= card_v2_q ? 32'h4000_0000 : 32'h0000_0000;
                    cmd_crc_q   <= 7'h7F;
                    cmd_nresp_q <= 3'd1;
                    state_q     <= StW41;
                end
                StC58: begin
                    cmd_start_q <= 1'b1;
                    cmd_index_q <= 6'd58;
                    cmd_arg_q   <= 32'h0000_0000;
                    cmd_crc_q   <= 7'h7F;
                    cmd_nresp_q <= 3'd5;
                    state_q     <= StW58;
                end
                StW0: begin
                    if (cmd_done_i) begin
                        if (resp_r1_i == 8'h01) begin
                            state_q <= StC8;
                        end else begin
                            c0_cnt_q <= c0_cnt_q + 1'b1;
                            if (c0_cnt_q >= C0Last) begin
                                state_q    <= StErr;
                                ss_n_q     <= 1'b1;
                                busy_q     <= 1'b0;
                                err_q      <= 1'b1;
                                err_code_q <= 3'd1;
                            end else begin
                                state_q <= StC0;
                            end
                        end
                    end
                end
                StW8: begin
                    if (cmd_done_i) begin
                        if (resp_r1_i == 8'h01 && resp_ext_i[11:0] == 12'h1AA) begin
                            card_v2_q <= 1'b1;
                            state_q   <= StC55;
                        end else if (resp_r1_i[2]) begin
                            card_v2_q <= 1'b0;
                            state_q   <= StC55;
                        end else begin
                            state_q    <= StErr;
                            ss_n_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= 3'd2;
                        end
                    end
                end
                StW55: begin
                    if (cmd_done_i) begin
                        if (resp_r1_i == 8'h00 || resp_r1_i == 8'h01) begin
                            state_q <= StC41;
                        end else begin
                            state_q    <= StErr;
                            ss_n_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= 3'd3;
                        end
                    end
                end
                StW41: begin
                    if (cmd_done_i) begin
                        if (resp_r1_i == 8'h00 && card_v2_q) begin
                            state_q <= StC58;
                        end else if (resp_r1_i == 8'h00) begin
                            state_q <= StDone;
                            ss_n_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ok_q    <= 1'b1;
                        end else if (resp_r1_i == 8'h01 && a41_cnt_q < A41Last) begin
                            a41_cnt_q <= a41_cnt_q + 1'b1;
                            state_q   <= StC55;
                        end else begin
                            if (resp_r1_i == 8'h01) a41_cnt_q <= a41_cnt_q + 1'b1;
                            state_q    <= StErr;
                            ss_n_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= (resp_r1_i == 8'h01) ? 3'd4 : 3'd3;
                        end
                    end
                end
                StW58: begin
                    if (cmd_done_i) begin
                        ss_n_q <= 1'b1;
                        busy_q <= 1'b0;
                        if (resp_r1_i == 8'h00) begin
                            card_hc_q <= resp_ext_i[30];
                            state_q   <= StDone;
                            ok_q      <= 1'b1;
                        end else begin
                            state_q    <= StErr;
                            err_q      <= 1'b1;
                            err_code_q <= 3'd5;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ss_n_o         = ss_n_q;
    assign dummy_start_o  = dummy_start_q;
    assign dummy_nbytes_o = 8'(POWERUP_BYTES);
    assign cmd_start_o    = cmd_start_q;
    assign cmd_index_o    = cmd_index_q;
    assign cmd_arg_o      = cmd_arg_q;
    assign cmd_crc_o      = cmd_crc_q;
    assign cmd_nresp_o    = cmd_nresp_q;
    assign init_busy_o    = busy_q;
    assign init_ok_o      = ok_q;
    assign init_err_o     = err_q;
    assign err_code_o     = err_code_q;
    assign card_v2_o      = card_v2_q;
    assign card_hc_o      = card_hc_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer: plays the command engine and card, checking command
// order, fields, 2-cycle issue latency, card classification and error codes.
module tb_sd_init_sequencer;

    logic        clk, rst_n, init_start, dummy_done, cmd_done;
    logic [7:0]  resp_r1;
    logic [31:0] resp_ext;
    logic        ss_n_o, dummy_start_o, cmd_start_o;
    logic [7:0]  dummy_nbytes_o;
    logic [5:0]  cmd_index_o;
    logic [31:0] cmd_arg_o;
    logic [6:0]  cmd_crc_o;
    logic [2:0]  cmd_nresp_o, err_code_o;
    logic        init_busy_o, init_ok_o, init_err_o, card_v2_o, card_hc_o;

    int vectors = 0;
    int miscompares = 0;

    sd_init_sequencer #(
        .CMD0_RETRIES   (8),
        .ACMD41_RETRIES (4),
        .POWERUP_BYTES  (10)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_start_i   (init_start),
        .ss_n_o         (ss_n_o),
        .dummy_start_o  (dummy_start_o),
        .dummy_nbytes_o (dummy_nbytes_o),
        .dummy_done_i   (dummy_done),
        .cmd_start_o    (cmd_start_o),
        .cmd_index_o    (cmd_index_o),
        .cmd_arg_o      (cmd_arg_o),
        .cmd_crc_o      (cmd_crc_o),
        .cmd_nresp_o    (cmd_nresp_o),
        .cmd_done_i     (cmd_done),
        .resp_r1_i      (resp_r1),
        .resp_ext_i     (resp_ext),
        .init_busy_o    (init_busy_o),
        .init_ok_o      (init_ok_o),
        .init_err_o     (init_err_o),
        .err_code_o     (err_code_o),
        .card_v2_o      (card_v2_o),
        .card_hc_o      (card_hc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {index, arg, crc, nresp} straight from the command table.
    function automatic logic [47:0] exp_fields(input int idx, input bit v2);
        case (idx)
            0:       return {6'd0, 32'h0000_0000, 7'h4A, 3'd1};
            8:       return {6'd8, 32'h0000_01AA, 7'h43, 3'd5};
            55:      return {6'd55, 32'h0000_0000, 7'h7F, 3'd1};
            41:      return {6'd41, v2 ? 32'h4000_0000 : 32'h0, 7'h7F, 3'd1};
            default: return {6'd58, 32'h0000_0000, 7'h7F, 3'd5};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(input int bound, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < bound) begin
            step();
            cyc++;
            if (cmd_start_o) got = 1'b1;
        end
    endtask

    // Engine takes one cycle, then returns the response with a one-cycle cmd_done.
    task automatic respond(input logic [7:0] r1, input logic [31:0] ext);
        step();
        cmd_done = 1'b1;
        resp_r1  = r1;
        resp_ext = ext;
        step();
        cmd_done = 1'b0;
        resp_r1  = 8'h00;
        resp_ext = 32'h0;
    endtask

    task automatic power_up(input bit stray, output bit ds_seen, output bit ssn_pwr);
        init_start = 1'b1;
        if (stray) begin
            cmd_done = 1'b1;
            resp_r1  = 8'h00;
        end
        step();
        init_start = 1'b0;
        cmd_done   = 1'b0;
        ds_seen    = dummy_start_o;
        step();
        step();
        ssn_pwr    = ss_n_o;
        dummy_done = 1'b1;
        step();
        dummy_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        vectors++;
        if ({ss_n_o, init_busy_o, init_ok_o, init_err_o, err_code_o, card_v2_o, card_hc_o,
             cmd_start_o, dummy_start_o} !== 11'b100_0000_0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got ss=%0b busy=%0b ok=%0b err=%0b code=%0d v2=%0b hc=%0b cs=%0b ds=%0b want ss=1 rest 0",
                     ss_n_o, init_busy_o, init_ok_o, init_err_o, err_code_o, card_v2_o,
                     card_hc_o, cmd_start_o, dummy_start_o);
        end
        vectors++;
        if (dummy_nbytes_o !== 8'd10) begin
            miscompares++;
            $display("FAIL dummy_nbytes: got %0d want 10", dummy_nbytes_o);
        end
        rst_n = 1'b1;
        step();
        step();
        vectors++;
        if ({ss_n_o, init_busy_o, dummy_start_o, cmd_start_o} !== 4'b1000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b want 1000", {ss_n_o, init_busy_o, dummy_start_o, cmd_start_o});
        end
    endtask

    task automatic test_v2_hc();
        int          idx[9] = '{0, 8, 55, 41, 55, 41, 55, 41, 58};
        logic [7:0]  r1[9]  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
        logic [31:0] ext[9] = '{0, 32'h0000_01AA, 0, 0, 0, 0, 0, 0, 32'hC0FF_8000};
        bit ds, ssn, got;
        int cyc;
        power_up(1'b0, ds, ssn);
        vectors++;
        if (ds !== 1'b1 || ssn !== 1'b1) begin
            miscompares++;
            $display("FAIL v2_powerup: got dummy_start=%0b ss_n=%0b want 1 1", ds, ssn);
        end
        for (int i = 0; i < 9; i++) begin
            wait_cmd(20, got, cyc);
            vectors++;
            if (got !== 1'b1 || cyc !== 1) begin
                miscompares++;
                $display("FAIL v2_issue_latency step%0d: got pulse=%0b after %0d cycles want 1 after 1", i, got, cyc);
            end
            vectors++;
            if ({cmd_index_o, cmd_arg_o, cmd_crc_o, cmd_nresp_o, ss_n_o, init_busy_o} !==
                {exp_fields(idx[i], 1'b1), 2'b01}) begin
                miscompares++;
                $display("FAIL v2_fields step%0d: got idx=%0d arg=%h crc=%h nresp=%0d ss=%0b busy=%0b want idx=%0d ss=0 busy=1",
                         i, cmd_index_o, cmd_arg_o, cmd_crc_o, cmd_nresp_o, ss_n_o, init_busy_o, idx[i]);
            end
            respond(r1[i], ext[i]);
        end
        vectors++;
        if ({init_ok_o, init_err_o, init_busy_o, card_v2_o, card_hc_o, err_code_o, ss_n_o} !==
            9'b1_0_0_1_1_000_1) begin
            miscompares++;
            $display("FAIL v2_done: got ok=%0b err=%0b busy=%0b v2=%0b hc=%0b code=%0d ss=%0b want 1 0 0 1 1 0 1",
                     init_ok_o, init_err_o, init_busy_o, card_v2_o, card_hc_o, err_code_o, ss_n_o);
        end
    endtask

    // Starts from DONE of a v2-HC card, with a stray cmd_done alongside init_start.
    task automatic test_v1_reinit();
        int          idx[4] = '{0, 8, 55, 41};
        logic [7:0]  r1[4]  = '{8'h01, 8'h05, 8'h01, 8'h00};
        bit ds, ssn, got;
        int cyc;
        power_up(1'b1, ds, ssn);
        vectors++;
        if ({ds, card_hc_o, card_v2_o, init_ok_o, init_busy_o} !== 5'b10001) begin
            miscompares++;
            $display("FAIL reinit_clear: got ds=%0b hc=%0b v2=%0b ok=%0b busy=%0b want 1 0 0 0 1",
                     ds, card_hc_o, card_v2_o, init_ok_o, init_busy_o);
        end
        for (int i = 0; i < 4; i++) begin
            wait_cmd(20, got, cyc);
            vectors++;
            if (got !== 1'b1 || {cmd_index_o, cmd_arg_o, cmd_crc_o, cmd_nresp_o} !== exp_fields(idx[i], 1'b0)) begin
                miscompares++;
                $display("FAIL v1_cmd step%0d: got pulse=%0b idx=%0d arg=%h want idx=%0d arg=0",
                         i, got, cmd_index_o, cmd_arg_o, idx[i]);
            end
            respond(r1[i], 32'h0);
        end
        vectors++;
        if ({init_ok_o, init_err_o, card_v2_o, card_hc_o, err_code_o} !== 7'b1_0_0_0_000) begin
            miscompares++;
            $display("FAIL v1_done: got ok=%0b err=%0b v2=%0b hc=%0b code=%0d want 1 0 0 0 0",
                     init_ok_o, init_err_o, card_v2_o, card_hc_o, err_code_o);
        end
        wait_cmd(20, got, cyc);
        vectors++;
        if (got !== 1'b0) begin
            miscompares++;
            $display("FAIL v1_no_cmd58: got extra cmd_start idx=%0d want none", cmd_index_o);
        end
    endtask

    task automatic test_dead_card();
        bit ds, ssn, got;
        int cyc;
        power_up(1'b0, ds, ssn);
        for (int i = 0; i < 8; i++) begin
            wait_cmd(20, got, cyc);
            vectors++;
            if (got !== 1'b1 || cmd_index_o !== 6'd0) begin
                miscompares++;
                $display("FAIL dead_cmd0 attempt%0d: got pulse=%0b idx=%0d want 1 0", i, got, cmd_index_o);
            end
            respond(8'hFF, 32'h0);
        end
        vectors++;
        if ({init_err_o, init_ok_o, init_busy_o, err_code_o, ss_n_o} !== 7'b1_0_0_001_1) begin
            miscompares++;
            $display("FAIL dead_err: got err=%0b ok=%0b busy=%0b code=%0d ss=%0b want 1 0 0 1 1",
                     init_err_o, init_ok_o, init_busy_o, err_code_o, ss_n_o);
        end
        wait_cmd(20, got, cyc);
        vectors++;
        if (got !== 1'b0) begin
            miscompares++;
            $display("FAIL dead_extra_cmd: got ninth cmd_start want none");
        end
    endtask

    task automatic test_cmd8_echo();
        bit ds, ssn, got;
        int cyc;
        power_up(1'b0, ds, ssn);
        vectors++;
        if ({ds, err_code_o, init_err_o} !== 5'b1_000_0) begin
            miscompares++;
            $display("FAIL echo_restart_from_err: got ds=%0b code=%0d err=%0b want 1 0 0", ds, err_code_o, init_err_o);
        end
        wait_cmd(20, got, cyc);
        respond(8'h01, 32'h0);
        wait_cmd(20, got, cyc);
        respond(8'h01, 32'h0000_01AB);
        vectors++;
        if ({init_err_o, err_code_o, init_busy_o} !== 5'b1_010_0) begin
            miscompares++;
            $display("FAIL echo_err: got err=%0b code=%0d busy=%0b want 1 2 0", init_err_o, err_code_o, init_busy_o);
        end
    endtask

    task automatic test_acmd41_timeout();
        bit ds, ssn, got;
        int cyc;
        power_up(1'b0, ds, ssn);
        wait_cmd(20, got, cyc);
        respond(8'h01, 32'h0);
        wait_cmd(20, got, cyc);
        // init_start while waiting on CMD8 must be ignored.
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        vectors++;
        if ({dummy_start_o, init_busy_o, ss_n_o} !== 3'b010) begin
            miscompares++;
            $display("FAIL busy_start_ignored: got ds=%0b busy=%0b ss=%0b want 0 1 0", dummy_start_o, init_busy_o, ss_n_o);
        end
        respond(8'h01, 32'h0000_01AA);
        for (int i = 0; i < 4; i++) begin
            wait_cmd(20, got, cyc);
            vectors++;
            if (got !== 1'b1 || cmd_index_o !== 6'd55) begin
                miscompares++;
                $display("FAIL to_cmd55 round%0d: got pulse=%0b idx=%0d want 1 55", i, got, cmd_index_o);
            end
            respond(8'h01, 32'h0);
            wait_cmd(20, got, cyc);
            vectors++;
            if (got !== 1'b1 || {cmd_index_o, cmd_arg_o} !== {6'd41, 32'h4000_0000}) begin
                miscompares++;
                $display("FAIL to_acmd41 round%0d: got pulse=%0b idx=%0d arg=%h want 1 41 40000000",
                         i, got, cmd_index_o, cmd_arg_o);
            end
            respond(8'h01, 32'h0);
        end
        vectors++;
        if ({init_err_o, err_code_o, card_v2_o, ss_n_o} !== 6'b1_100_1_1) begin
            miscompares++;
            $display("FAIL acmd41_timeout: got err=%0b code=%0d v2=%0b ss=%0b want 1 4 1 1",
                     init_err_o, err_code_o, card_v2_o, ss_n_o);
        end
    endtask

    task automatic test_reset_in_w41();
        bit ds, ssn, got;
        int cyc;
        power_up(1'b0, ds, ssn);
        wait_cmd(20, got, cyc);
        respond(8'h01, 32'h0);
        wait_cmd(20, got, cyc);
        respond(8'h01, 32'h0000_01AA);
        wait_cmd(20, got, cyc);
        respond(8'h01, 32'h0);
        wait_cmd(20, got, cyc);
        step();
        rst_n = 1'b0;
        step();
        vectors++;
        if ({ss_n_o, cmd_start_o, init_busy_o, card_v2_o} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_w41: got ss=%0b cs=%0b busy=%0b v2=%0b want 1 0 0 0",
                     ss_n_o, cmd_start_o, init_busy_o, card_v2_o);
        end
        rst_n = 1'b1;
        step();
        power_up(1'b0, ds, ssn);
        vectors++;
        if ({ds, ssn} !== 2'b11) begin
            miscompares++;
            $display("FAIL restart_powerup: got dummy_start=%0b ss_n_in_pwr=%0b want 1 1", ds, ssn);
        end
        wait_cmd(20, got, cyc);
        vectors++;
        if (got !== 1'b1 || cmd_index_o !== 6'd0 || ss_n_o !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_cmd0: got pulse=%0b idx=%0d ss=%0b want 1 0 0", got, cmd_index_o, ss_n_o);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        init_start = 1'b0;
        dummy_done = 1'b0;
        cmd_done   = 1'b0;
        resp_r1    = 8'h00;
        resp_ext   = 32'h0;
        test_reset();
        test_v2_hc();
        test_v1_reinit();
        test_dead_card();
        test_cmd8_echo();
        test_acmd41_timeout();
        test_reset_in_w41();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
